// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Definitions shared by the PWM capture block and the LED PWM generators.
// It holds the capture FSM state encoding and the default counter width,
// timeout and synchronizer depth. The PWM generators use the same width for
// their step and pwm counters.
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int DEFAULT_CNT_WIDTH   = 18;
    localparam int DEFAULT_TIMEOUT     = 200000;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous input into the clock domain through a flop chain,
// then detects rising and falling edges against one more register.
// It can be reused for button inputs.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset; clears the chain and edge reg
//   din    in   asynchronous input
//   level  out  synchronized level (last stage of the chain)
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge
    import pwm_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures the high time and period of an external PWM waveform in sys_clk
// cycles. Each complete rise-to-rise period is published with a one-cycle
// valid strobe. If no qualifying edge arrives within TIMEOUT cycles, the
// block enters STUCK. On that entry it publishes zeros and records the
// stuck level.
//
// Ports:
//   sys_clk      in   sole clock
//   sys_rst      in   synchronous active-high reset
//   pwm_in       in   asynchronous PWM input
//   enable       in   0 holds the FSM in IDLE and clears the counters
//   valid        out  one-cycle strobe; the data outputs update with it
//   high_cnt     out  last measured high time
//   period_cnt   out  last measured period
//   stuck        out  1 while the FSM is in STUCK
//   stuck_level  out  synchronized input level captured on STUCK entry
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 pwm_in,
    input  logic                 enable,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] high_cnt,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic                 stuck,
    output logic                 stuck_level
);

    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic                 s;
    logic                 rise;
    logic                 fall;
    cap_state_t           state;
    cap_state_t           next_state;
    logic [CNT_WIDTH-1:0] period_ctr;
    logic [CNT_WIDTH-1:0] high_ctr;
    logic [CNT_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0] period_inc;
    logic                 timed_out;
    logic                 publish;
    logic                 enter_stuck;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .din   (pwm_in),
        .level (s),
        .rise  (rise),
        .fall  (fall)
    );

    // The timer counts cycles since the last qualifying edge (or since
    // IDLE entry). The timeout fires on the cycle the count reaches TIMEOUT.
    assign timed_out = (timer >= TIMER_LAST);

    // A full high phase followed by a full low phase can approach twice
    // TIMEOUT. The period counter therefore saturates instead of wrapping.
    assign period_inc = (period_ctr == CNT_MAX) ? period_ctr : period_ctr + ONE;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An edge always takes priority over a timeout in the same cycle.
    // A fall is only meaningful in HIGH.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise)           next_state = ST_HIGH;
                    else if (timed_out) next_state = ST_STUCK;
                end
                ST_HIGH: begin
                    if (fall)           next_state = ST_LOW;
                    else if (timed_out) next_state = ST_STUCK;
                end
                ST_LOW: begin
                    if (rise)           next_state = ST_HIGH;
                    else if (timed_out) next_state = ST_STUCK;
                end
                ST_STUCK: begin
                    if (rise)           next_state = ST_HIGH;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stuck       = (state == ST_STUCK);
        publish     = enable && (state == ST_LOW) && rise;
        enter_stuck = enable && (state != ST_STUCK) && (next_state == ST_STUCK);
    end

    // Measurement counters. A rise that starts a period loads 1 into both
    // counters, so each counter equals the cycle distance to the edge that
    // ends it. The high counter holds its value through the LOW phase.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !enable || enter_stuck) begin
            period_ctr <= '0;
            high_ctr   <= '0;
            timer      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        period_ctr <= ONE;
                        high_ctr   <= ONE;
                        timer      <= '0;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                ST_HIGH: begin
                    period_ctr <= period_inc;
                    if (fall) begin
                        timer <= '0;
                    end else begin
                        high_ctr <= high_ctr + ONE;
                        timer    <= timer + ONE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_ctr <= ONE;
                        high_ctr   <= ONE;
                        timer      <= '0;
                    end else begin
                        period_ctr <= period_inc;
                        timer      <= timer + ONE;
                    end
                end
                ST_STUCK: begin
                    if (rise) begin
                        period_ctr <= ONE;
                        high_ctr   <= ONE;
                        timer      <= '0;
                    end
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

    // Published results. These keep their last values while the block is
    // disabled. Only reset clears them.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            valid       <= 1'b0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (publish) begin
                valid      <= 1'b1;
                high_cnt   <= high_ctr;
                period_cnt <= period_ctr;
            end else if (enter_stuck) begin
                valid       <= 1'b1;
                high_cnt    <= '0;
                period_cnt  <= '0;
                stuck_level <= s;
            end
        end
    end

endmodule
